// File: rtl/dso_pkg.sv
// Shared types and constants for the DSO trigger/capture stage.
// Contents:
//   dso_state_e  - capture FSM states
//   EDGE_RISE/EDGE_FALL - trig_edge encodings
//   level_cross  - level-crossing test between two consecutive samples
package dso_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StPretrig,
        StWaitTrig,
        StPostTrig,
        StReadout
    } dso_state_e;

    localparam logic EDGE_RISE = 1'b0;
    localparam logic EDGE_FALL = 1'b1;

    // True when the step prev -> cur crosses level in the selected direction.
    function automatic logic level_cross(input logic       edge_sel,
                                         input logic [7:0] prev,
                                         input logic [7:0] cur,
                                         input logic [7:0] level);
        logic rise;
        logic fall;
        rise = (prev < level) && (cur >= level);
        fall = (prev >= level) && (cur < level);
        return ((edge_sel == EDGE_RISE) && rise) || ((edge_sel == EDGE_FALL) && fall);
    endfunction

endpackage

// File: rtl/dso_sdp_ram.sv
// Simple dual-port RAM: one write port, one read port with a registered output
// (one cycle read latency). Written in the plain style block-RAM inference expects.
// Ports:
//   clk_i            - clock
//   we_i/waddr_i/wdata_i - write port
//   re_i/raddr_i     - read request; data appears on rdata_o the next cycle
//   rdata_o          - registered read data
module dso_sdp_ram #(
    parameter int unsigned Width = 8,
    parameter int unsigned AddrW = 10
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AddrW-1:0] waddr_i,
    input  logic [Width-1:0] wdata_i,
    input  logic             re_i,
    input  logic [AddrW-1:0] raddr_i,
    output logic [Width-1:0] rdata_o
);

    logic [Width-1:0] mem_q [2**AddrW];
    logic [Width-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dso_trig_capture.sv
// Pre/post-trigger capture stage. Records a circular window of 2**DEPTH_LOG2
// samples around a level-crossing (or forced) trigger, then streams the frame
// oldest-first over valid/ready. One arm produces one frame.
// Ports:
//   ad_clk_i, rst_ni       - sample clock, async active-low reset
//   ad_data_i              - unsigned sample, valid every cycle
//   arm_i                  - start a capture (only honoured in idle)
//   force_trig_i           - trigger on the current sample while waiting
//   trig_level_i/trig_edge_i/pre_len_i - capture setup, latched at arm
//   out_data_o/out_valid_o/out_ready_i/out_last_o - frame stream
//   busy_o                 - capture in progress
//   done_o                 - one-cycle pulse after the final handshake
module dso_trig_capture
    import dso_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 10
) (
    input  logic                  ad_clk_i,
    input  logic                  rst_ni,
    input  logic [7:0]            ad_data_i,
    input  logic                  arm_i,
    input  logic                  force_trig_i,
    input  logic [7:0]            trig_level_i,
    input  logic                  trig_edge_i,
    input  logic [DEPTH_LOG2-1:0] pre_len_i,
    output logic [7:0]            out_data_o,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic                  out_last_o,
    output logic                  busy_o,
    output logic                  done_o
);

    typedef logic [DEPTH_LOG2-1:0] ptr_t;
    typedef logic [DEPTH_LOG2:0]   cnt_t;

    localparam cnt_t FrameLen = cnt_t'(1) << DEPTH_LOG2;

    dso_state_e state_q, state_d;
    logic [7:0] level_q, level_d;
    logic       edge_q, edge_d;
    ptr_t       pre_q, pre_d;
    ptr_t       wptr_q, wptr_d;
    ptr_t       raddr_q, raddr_d;
    cnt_t       cnt_q, cnt_d;
    cnt_t       rd_cnt_q, rd_cnt_d;
    logic [7:0] prev_q;
    logic       prev_valid_q;
    logic       inflight_q, inflight_last_q;
    logic       done_q, done_d;

    // Two-entry output buffer
    logic [7:0] buf_data_q [2];
    logic [1:0] buf_last_q;
    logic       buf_wr_q, buf_rd_q;
    logic [1:0] buf_cnt_q;

    logic       ram_we, ram_re;
    logic [7:0] ram_rdata;
    logic       trig_hit;
    logic       push, pop;
    logic [1:0] occ;
    cnt_t       pre_ext, post_len;

    dso_sdp_ram #(
        .Width (8),
        .AddrW (DEPTH_LOG2)
    ) u_ram (
        .clk_i   (ad_clk_i),
        .we_i    (ram_we),
        .waddr_i (wptr_q),
        .wdata_i (ad_data_i),
        .re_i    (ram_re),
        .raddr_i (raddr_q),
        .rdata_o (ram_rdata)
    );

    assign pre_ext  = {1'b0, pre_q};
    assign post_len = FrameLen - cnt_t'(1) - pre_ext;

    // No edge on the first waiting cycle: prev_q still holds a pretrigger sample.
    assign trig_hit = force_trig_i ||
                      (prev_valid_q && level_cross(edge_q, prev_q, ad_data_i, level_q));

    assign out_valid_o = (buf_cnt_q != 2'd0);
    assign out_data_o  = buf_data_q[buf_rd_q];
    assign out_last_o  = out_valid_o & buf_last_q[buf_rd_q];
    assign pop         = out_valid_o & out_ready_i;
    assign push        = inflight_q;
    // Occupancy the buffer will have next cycle, before a read issued now lands.
    assign occ         = buf_cnt_q + 2'(inflight_q) - 2'(pop);

    assign busy_o = (state_q != StIdle);
    assign done_o = done_q;

    always_comb begin
        state_d  = state_q;
        level_d  = level_q;
        edge_d   = edge_q;
        pre_d    = pre_q;
        cnt_d    = cnt_q;
        raddr_d  = raddr_q;
        rd_cnt_d = rd_cnt_q;
        done_d   = 1'b0;
        ram_we   = 1'b0;
        ram_re   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (arm_i) begin
                    level_d = trig_level_i;
                    edge_d  = trig_edge_i;
                    // pre_len_i is DEPTH_LOG2 bits wide, so it never exceeds N-1.
                    pre_d   = pre_len_i;
                    cnt_d   = '0;
                    state_d = (pre_len_i == '0) ? StWaitTrig : StPretrig;
                end
            end
            StPretrig: begin
                ram_we = 1'b1;
                cnt_d  = cnt_q + cnt_t'(1);
                if (cnt_q + cnt_t'(1) == pre_ext) begin
                    state_d = StWaitTrig;
                end
            end
            StWaitTrig: begin
                ram_we = 1'b1;
                if (trig_hit) begin
                    raddr_d  = wptr_q - pre_q;
                    rd_cnt_d = '0;
                    cnt_d    = '0;
                    state_d  = (post_len == '0) ? StReadout : StPostTrig;
                end
            end
            StPostTrig: begin
                ram_we = 1'b1;
                cnt_d  = cnt_q + cnt_t'(1);
                if (cnt_q + cnt_t'(1) == post_len) begin
                    state_d = StReadout;
                end
            end
            StReadout: begin
                ram_re = (rd_cnt_q != FrameLen) && (occ < 2'd2);
                if (ram_re) begin
                    raddr_d  = raddr_q + ptr_t'(1);
                    rd_cnt_d = rd_cnt_q + cnt_t'(1);
                end
                if (pop && out_last_o) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign wptr_d = wptr_q + ptr_t'(ram_we);

    always_ff @(posedge ad_clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q         <= StIdle;
            level_q         <= '0;
            edge_q          <= EDGE_RISE;
            pre_q           <= '0;
            wptr_q          <= '0;
            raddr_q         <= '0;
            cnt_q           <= '0;
            rd_cnt_q        <= '0;
            prev_q          <= '0;
            prev_valid_q    <= 1'b0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            level_q         <= level_d;
            edge_q          <= edge_d;
            pre_q           <= pre_d;
            wptr_q          <= wptr_d;
            raddr_q         <= raddr_d;
            cnt_q           <= cnt_d;
            rd_cnt_q        <= rd_cnt_d;
            prev_q          <= ad_data_i;
            prev_valid_q    <= (state_q == StWaitTrig);
            inflight_q      <= ram_re;
            inflight_last_q <= ram_re && (rd_cnt_q == FrameLen - cnt_t'(1));
            done_q          <= done_d;
        end
    end

    always_ff @(posedge ad_clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            buf_data_q[0] <= '0;
            buf_data_q[1] <= '0;
            buf_last_q    <= '0;
            buf_wr_q      <= 1'b0;
            buf_rd_q      <= 1'b0;
            buf_cnt_q     <= '0;
        end else begin
            if (push) begin
                buf_data_q[buf_wr_q] <= ram_rdata;
                buf_last_q[buf_wr_q] <= inflight_last_q;
                buf_wr_q             <= ~buf_wr_q;
            end
            if (pop) begin
                buf_rd_q <= ~buf_rd_q;
            end
            buf_cnt_q <= buf_cnt_q + 2'(push) - 2'(pop);
        end
    end

endmodule

// File: tb/tb_dso_trig_capture.sv
module tb_dso_trig_capture;

    localparam int unsigned DL = 4;
    localparam int N = 16;
    localparam int HistLen = 20000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [7:0]    ad_data = '0;
    logic          arm = 1'b0;
    logic          force_trig = 1'b0;
    logic [7:0]    trig_level = '0;
    logic          trig_edge = 1'b0;
    logic [DL-1:0] pre_len = '0;
    logic [7:0]    out_data;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic          out_last;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    dso_trig_capture #(
        .DEPTH_LOG2 (DL)
    ) dut (
        .ad_clk_i     (clk),
        .rst_ni       (rst_n),
        .ad_data_i    (ad_data),
        .arm_i        (arm),
        .force_trig_i (force_trig),
        .trig_level_i (trig_level),
        .trig_edge_i  (trig_edge),
        .pre_len_i    (pre_len),
        .out_data_o   (out_data),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .out_last_o   (out_last),
        .busy_o       (busy),
        .done_o       (done)
    );

    int n_chk = 0;
    int n_err = 0;

    // Reference model: sample history plus the rules for when a frame triggers.
    logic [7:0] hist [HistLen];
    int         cyc = 0;
    bit         m_busy = 0, m_found = 0, done_pend = 0;
    int         m_wait, m_trig, m_pre, m_idx;
    logic [7:0] m_lvl;
    logic       m_edge;
    bit         stall_prev = 0;
    logic [7:0] stall_data;
    logic       stall_last;
    logic [7:0] rx [N];
    logic       rx_last [N];
    int         frames_done = 0;
    int         done_pulses = 0;
    bit         rand_ready = 0;
    logic [7:0] pat [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit crosses(logic e, logic [7:0] p, logic [7:0] c, logic [7:0] l);
        if (e) return (p >= l) && (c < l);
        return (p < l) && (c >= l);
    endfunction

    always @(negedge clk) begin
        bit busy_before;
        bit exp_done;
        if (!rst_n) begin
            check("rst_out_valid", {31'd0, out_valid}, 0);
            check("rst_out_data", {24'd0, out_data}, 0);
            check("rst_out_last", {31'd0, out_last}, 0);
            check("rst_busy", {31'd0, busy}, 0);
            check("rst_done", {31'd0, done}, 0);
            m_busy     = 0;
            m_found    = 0;
            done_pend  = 0;
            stall_prev = 0;
        end else begin
            exp_done  = done_pend;
            done_pend = 0;
            if (done) done_pulses++;
            check("busy", {31'd0, busy}, {31'd0, m_busy});
            check("done", {31'd0, done}, {31'd0, exp_done});
            if (stall_prev) begin
                check("stall_valid", {31'd0, out_valid}, 1);
                check("stall_data", {24'd0, out_data}, {24'd0, stall_data});
                check("stall_last", {31'd0, out_last}, {31'd0, stall_last});
            end
            if (out_valid && !(m_busy && m_found)) check("valid_unexpected", {31'd0, out_valid}, 0);
            busy_before = m_busy;
            if (out_valid && out_ready && m_busy && m_found && m_idx < N) begin
                check("frame_data", {24'd0, out_data}, {24'd0, hist[m_trig - m_pre + m_idx]});
                check("frame_last", {31'd0, out_last}, (m_idx == N - 1) ? 32'd1 : 32'd0);
                rx[m_idx]      = out_data;
                rx_last[m_idx] = out_last;
                m_idx++;
                if (m_idx == N) begin
                    m_busy    = 0;
                    m_found   = 0;
                    done_pend = 1;
                    frames_done++;
                end
            end
            stall_prev = out_valid && !out_ready;
            stall_data = out_data;
            stall_last = out_last;

            hist[cyc] = ad_data;
            if (m_busy && !m_found && cyc >= m_wait) begin
                if (force_trig || (cyc > m_wait && crosses(m_edge, hist[cyc-1], ad_data, m_lvl))) begin
                    m_found = 1;
                    m_trig  = cyc;
                    m_idx   = 0;
                end
            end
            if (!busy_before && arm) begin
                m_busy  = 1;
                m_found = 0;
                m_pre   = int'(pre_len);
                m_lvl   = trig_level;
                m_edge  = trig_edge;
                m_wait  = cyc + 1 + int'(pre_len);
            end
        end
        cyc++;
    end

    initial forever begin
        @(posedge clk);
        #1;
        out_ready = rand_ready ? ($urandom_range(0, 99) < 30) : 1'b1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_arm(input logic [DL-1:0] pre, input logic [7:0] lvl, input logic e);
        pre_len    = pre;
        trig_level = lvl;
        trig_edge  = e;
        ad_data    = 8'h00;
        arm        = 1'b1;
        tick();
        arm        = 1'b0;
    endtask

    // Drive pat[] from the cycle after arm until the frame completes.
    task automatic run_frame(input int budget, input bit arm_in_readout, input int force_at);
        int start;
        int k;
        bit sent;
        start = frames_done;
        k     = 0;
        sent  = 0;
        while (frames_done == start && k < budget) begin
            ad_data    = (k < pat.size()) ? pat[k] : 8'h00;
            force_trig = (k == force_at);
            if (arm_in_readout && !sent && out_valid) begin
                arm     = 1'b1;
                pre_len = 4'd9;
                sent    = 1;
            end
            tick();
            arm        = 1'b0;
            force_trig = 1'b0;
            k++;
        end
        n_chk++;
        if (frames_done == start) begin
            n_err++;
            $display("FAIL frame_timeout: no frame end within %0d cycles", budget);
        end
        ad_data = 8'h00;
        tick();
    endtask

    task automatic ramp_pat();
        pat.delete();
        for (int i = 0; i < 40; i++) pat.push_back(8'(i * 16));
    endtask

    initial begin
        logic [7:0] rxa [N];
        int bad;
        #1 rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        check("idle_busy", {31'd0, busy}, 0);

        // Rising trigger on a ramp
        ramp_pat();
        do_arm(4'd4, 8'h80, 1'b0);
        run_frame(300, 0, -1);
        check("ramp_s4", {24'd0, rx[4]}, 32'h80);
        check("ramp_s3", {24'd0, rx[3]}, 32'h70);
        check("ramp_s15", {24'd0, rx[15]}, 32'h30);
        check("ramp_last", {31'd0, rx_last[15]}, 1);
        check("ramp_done_pulses", done_pulses, 1);

        // Falling trigger; the long hold below the level must not fire
        pat.delete();
        repeat (50) pat.push_back(8'h20);
        pat.push_back(8'h50);
        repeat (31) pat.push_back(8'h30);
        do_arm(4'd4, 8'h40, 1'b1);
        run_frame(400, 0, -1);
        check("fall_trig", {24'd0, rx[4]}, 32'h30);
        check("fall_s3", {24'd0, rx[3]}, 32'h50);
        check("fall_s0", {24'd0, rx[0]}, 32'h20);
        check("fall_done_pulses", done_pulses, 2);

        // pre_len = 0: trigger sample leads the frame
        pat.delete();
        repeat (3) pat.push_back(8'h10);
        pat.push_back(8'h90);
        repeat (20) pat.push_back(8'($urandom_range(0, 255)));
        do_arm(4'd0, 8'h80, 1'b0);
        run_frame(300, 0, -1);
        check("pre0_first", {24'd0, rx[0]}, 32'h90);

        // pre_len = 15: trigger sample ends the frame
        pat.delete();
        repeat (20) pat.push_back(8'h10);
        pat.push_back(8'h90);
        repeat (20) pat.push_back(8'($urandom_range(0, 255)));
        do_arm(4'd15, 8'h80, 1'b0);
        run_frame(300, 0, -1);
        check("pre15_last_data", {24'd0, rx[15]}, 32'h90);
        check("pre15_last_flag", {31'd0, rx_last[15]}, 1);
        check("pre15_s14", {24'd0, rx[14]}, 32'h10);

        // force_trig in idle does nothing; in WAIT_TRIG it triggers
        ad_data    = 8'h55;
        force_trig = 1'b1;
        tick();
        force_trig = 1'b0;
        check("idle_force_busy", {31'd0, busy}, 0);
        pat.delete();
        repeat (40) pat.push_back(8'h55);
        do_arm(4'd8, 8'h00, 1'b0);
        run_frame(300, 0, 12);
        bad = 0;
        for (int i = 0; i < N; i++) if (rx[i] !== 8'h55) bad++;
        check("force_frame_all55", bad, 0);

        // Backpressure: same frame with and without stalls
        pat.delete();
        repeat (30) pat.push_back(8'($urandom_range(0, 255)));
        pat.push_back(8'h00);
        pat.push_back(8'hFF);
        repeat (30) pat.push_back(8'($urandom_range(0, 255)));
        do_arm(4'd6, 8'h80, 1'b0);
        run_frame(300, 0, -1);
        for (int i = 0; i < N; i++) rxa[i] = rx[i];
        rand_ready = 1;
        do_arm(4'd6, 8'h80, 1'b0);
        run_frame(2000, 0, -1);
        rand_ready = 0;
        bad = 0;
        for (int i = 0; i < N; i++) if (rx[i] !== rxa[i]) bad++;
        check("bp_frame_equal", bad, 0);

        // Reset mid-POSTTRIG, then a clean re-arm with an ignored arm in READOUT
        pat.delete();
        repeat (5) pat.push_back(8'h00);
        pat.push_back(8'hA0);
        repeat (20) pat.push_back(8'h33);
        do_arm(4'd2, 8'h80, 1'b0);
        for (int k = 0; k < 9; k++) begin
            ad_data = pat[k];
            tick();
        end
        check("pre_reset_busy", {31'd0, busy}, 1);
        rst_n = 1'b0;
        tick();
        check("mid_reset_valid", {31'd0, out_valid}, 0);
        tick();
        rst_n = 1'b1;
        tick();
        check("post_reset_busy", {31'd0, busy}, 0);
        ramp_pat();
        do_arm(4'd4, 8'h80, 1'b0);
        run_frame(300, 1, -1);
        check("rearm_s4", {24'd0, rx[4]}, 32'h80);
        check("rearm_s3", {24'd0, rx[3]}, 32'h70);
        repeat (4) tick();
        check("readout_arm_ignored", {31'd0, busy}, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule
